// File: rtl/bcd_to_binary_seq_if.sv
// Handshake/result bundle for the sequential BCD-to-binary converter.
// master: requester (drives start/bcd); slave: converter (drives status/results).
interface bcd_to_binary_seq_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 8
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      binary;
  logic                  err_digit;
  logic                  overflow;

  modport master (
    output start, bcd,
    input  busy, done, binary, err_digit, overflow
  );

  modport slave (
    input  start, bcd,
    output busy, done, binary, err_digit, overflow
  );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per clock).
// Optional build macro: BCD2BIN_SATURATE_EN -- when defined, an overflowing
// result is reported as all-ones instead of value mod 2**BIN_W.
module bcd_to_binary_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_to_binary_seq_if.slave    bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int TMP_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [TMP_W-1:0]   tmp_q, tmp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BIN_W-1:0]   binary_q, binary_d;
  logic               err_digit_q, err_digit_d;
  logic               overflow_q, overflow_d;

  logic [TMP_W-1:0]   shifted;
  logic [TMP_W-1:0]   adjusted;
  logic [DIGITS-1:0]  nib_bad;
  logic               digit_bad;
  logic               last_shift;

  // One iteration: shift right, then correct every BCD nibble that became >= 8.
  assign shifted                = tmp_q >> 1;
  assign adjusted[BIN_W-1:0]    = shifted[BIN_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign adjusted[BIN_W+4*gi +: 4] = (shifted[BIN_W+4*gi +: 4] >= 4'd8)
                                        ? shifted[BIN_W+4*gi +: 4] - 4'd3
                                        : shifted[BIN_W+4*gi +: 4];
      // In CHECK tmp still holds the raw operand in its upper BCD field.
      assign nib_bad[gi] = (tmp_q[BIN_W+4*gi +: 4] > 4'd9);
    end
  endgenerate

  assign digit_bad  = |nib_bad;
  assign last_shift = (cnt_q == CNT_W'(BIN_W - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CHECK;
      CHECK:   state_d = digit_bad ? DONE : SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    tmp_d       = tmp_q;
    cnt_d       = cnt_q;
    binary_d    = binary_q;
    err_digit_d = err_digit_q;
    overflow_d  = overflow_q;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (bus.start) tmp_d = {bus.bcd, {BIN_W{1'b0}}};
      end
      CHECK: begin
        cnt_d = '0;
        if (digit_bad) begin
          err_digit_d = 1'b1;
          overflow_d  = 1'b0;
          binary_d    = '0;
        end
      end
      SHIFT: begin
        tmp_d = adjusted;
        if (last_shift) begin
          err_digit_d = 1'b0;
          overflow_d  = |adjusted[TMP_W-1:BIN_W];
`ifdef BCD2BIN_SATURATE_EN
          binary_d    = (|adjusted[TMP_W-1:BIN_W]) ? {BIN_W{1'b1}} : adjusted[BIN_W-1:0];
`else
          binary_d    = adjusted[BIN_W-1:0];
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset clears everything and aborts a conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmp_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      binary_q    <= '0;
      err_digit_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      tmp_q       <= tmp_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      binary_q    <= binary_d;
      err_digit_q <= err_digit_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.binary    = binary_q;
  assign bus.err_digit = err_digit_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed testbench for bcd_to_binary_seq (DIGITS=3, BIN_W=8).
module tb_bcd_to_binary_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

`ifdef BCD2BIN_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  bcd_to_binary_seq_if #(.DIGITS(3), .BIN_W(8)) bus ();

  bcd_to_binary_seq #(.DIGITS(3), .BIN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One conversion: start accepted at edge N, done expected #1 after edge N+lat.
  task automatic convert(input logic [11:0] v, input logic [7:0] eb,
                         input logic eo, input logic ee);
    int lat;
    int exp_lat;
    exp_lat = ee ? 1 : 9;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd   = v;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.bcd   = 12'hFFF;  // must not disturb the captured operand
    check("busy_after_start", bus.busy, 1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.done && lat < 40);
    check("latency", lat, exp_lat);
    check("done", bus.done, 1);
    check("binary", bus.binary, eb);
    check("overflow", bus.overflow, eo);
    check("err_digit", bus.err_digit, ee);
    $display("txn bcd=%03h binary=%02h overflow=%0b err_digit=%0b latency=%0d",
             v, bus.binary, bus.overflow, bus.err_digit, lat);
    @(posedge clk); #1;
    check("done_one_cycle", bus.done, 0);
    check("idle_after_done", bus.busy, 0);
  endtask

  initial begin
    int lat;
    int seen;
    bus.start = 1'b0;
    bus.bcd   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_binary", bus.binary, 0);
    check("rst_err", bus.err_digit, 0);
    check("rst_ovf", bus.overflow, 0);
    rst = 1'b0;

    // Main function and boundaries
    convert(12'h255, 8'hFF, 1'b0, 1'b0);
    convert(12'h000, 8'h00, 1'b0, 1'b0);
    convert(12'h128, 8'h80, 1'b0, 1'b0);
    convert(12'h042, 8'h2A, 1'b0, 1'b0);
    convert(12'h090, 8'h5A, 1'b0, 1'b0);
    convert(12'h256, SAT ? 8'hFF : 8'h00, 1'b1, 1'b0);
    convert(12'h1A3, 8'h00, 1'b0, 1'b1);
    convert(12'h00F, 8'h00, 1'b0, 1'b1);
    convert(12'h999, SAT ? 8'hFF : 8'hE7, 1'b1, 1'b0);

    // Reset during SHIFT cycle 4 aborts the conversion
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd   = 12'h128;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_binary", bus.binary, 0);
    check("abort_ovf", bus.overflow, 0);
    check("abort_err", bus.err_digit, 0);
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    check("abort_no_done", seen, 0);
    $display("txn reset-abort bcd=128 dones_after=%0d", seen);
    convert(12'h100, 8'h64, 1'b0, 1'b0);

    // start pulsed throughout busy, including the DONE cycle, is ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd   = 12'h255;
    @(posedge clk); #1;
    bus.bcd   = 12'h042;   // start stays high
    lat  = 0;
    seen = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.done && lat < 40);
    check("busy_ign_latency", lat, 9);
    check("busy_ign_binary", bus.binary, 8'hFF);
    @(posedge clk); #1;    // DONE cycle sampled start=1 here
    bus.start = 1'b0;
    check("busy_ign_idle", bus.busy, 0);
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    check("busy_ign_extra_done", seen, 0);
    check("busy_ign_hold", bus.binary, 8'hFF);
    $display("txn busy-ignore bcd=255 binary=%02h extra_dones=%0d", bus.binary, seen);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
